// File: rtl/sram_ctrl_pkg.sv
// Shared widths, FSM states and request payload for the SRAM port arbiter.
package sram_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH_D = 6;
  localparam int unsigned DATA_WIDTH_D = 33;
  localparam int unsigned NUM_WMASKS_D = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic                    we;
    logic [NUM_WMASKS_D-1:0] wmask;
    logic                    spare_wen;
    logic [ADDR_WIDTH_D-1:0] addr;
    logic [DATA_WIDTH_D-1:0] wdata;
  } req_t;

endpackage

// File: rtl/sram_rr_arb.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant pointer.
module sram_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt_c
);

  logic r_last;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    o_gnt_c = 2'b00;
    if (i_en) begin
      if (&i_req) o_gnt_c = r_last ? 2'b01 : 2'b10;
      else        o_gnt_c = i_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_last <= 1'b1;
    else if (|o_gnt_c) r_last <= o_gnt_c[1];
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester access controller for a 1RW OpenRAM macro port.
// Define SRAM_ARB_INIT_EN to zero-fill the array after reset before accepting requests.
module sram_port_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_D,
  parameter int unsigned NUM_WMASKS = NUM_WMASKS_D
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_we,
  input  logic [NUM_WMASKS-1:0] r0_wmask,
  input  logic                  r0_spare_wen,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_we,
  input  logic [NUM_WMASKS-1:0] r1_wmask,
  input  logic                  r1_spare_wen,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic                  sram_spare_wen0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  init_done
);

`ifdef SRAM_ARB_INIT_EN
  localparam state_e RESET_STATE = INIT;
`else
  localparam state_e RESET_STATE = RUN;
`endif

  state_e                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_init_cnt, w_init_cnt_nxt;
  logic                  r_init_done;
  logic                  r_csb0, w_csb0_nxt;
  logic                  r_web0, w_web0_nxt;
  logic [NUM_WMASKS-1:0] r_wmask0, w_wmask0_nxt;
  logic                  r_spare0, w_spare0_nxt;
  logic [ADDR_WIDTH-1:0] r_addr0, w_addr0_nxt;
  logic [DATA_WIDTH-1:0] r_din0, w_din0_nxt;
  logic                  w_push, w_push_own;
  logic                  r_t1_vld, r_t1_own, r_t2_vld, r_t2_own;
  logic                  r_rvalid0, r_rvalid1;
  logic [DATA_WIDTH-1:0] r_rdata0, r_rdata1;
  logic [1:0]            w_gnt;
  logic                  w_accept;
  req_t                  w_req0, w_req1, w_sel;

  sram_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (r_state == RUN),
    .i_req   ({r1_valid, r0_valid}),
    .o_gnt_c (w_gnt)
  );

  assign w_req0 = '{we: r0_we, wmask: NUM_WMASKS_D'(r0_wmask), spare_wen: r0_spare_wen,
                    addr: ADDR_WIDTH_D'(r0_addr), wdata: DATA_WIDTH_D'(r0_wdata)};
  assign w_req1 = '{we: r1_we, wmask: NUM_WMASKS_D'(r1_wmask), spare_wen: r1_spare_wen,
                    addr: ADDR_WIDTH_D'(r1_addr), wdata: DATA_WIDTH_D'(r1_wdata)};
  assign w_sel    = w_gnt[1] ? w_req1 : w_req0;
  assign w_accept = |w_gnt;

  // Next state, init sweep and macro pin values; idle cycles deselect but hold addr/data/mask.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_csb0_nxt     = 1'b1;
    w_web0_nxt     = 1'b1;
    w_wmask0_nxt   = r_wmask0;
    w_spare0_nxt   = r_spare0;
    w_addr0_nxt    = r_addr0;
    w_din0_nxt     = r_din0;
    w_push         = 1'b0;
    w_push_own     = 1'b0;
    case (r_state)
      INIT: begin
        w_csb0_nxt     = 1'b0;
        w_web0_nxt     = 1'b0;
        w_wmask0_nxt   = '1;
        w_spare0_nxt   = 1'b1;
        w_addr0_nxt    = r_init_cnt;
        w_din0_nxt     = '0;
        w_init_cnt_nxt = ADDR_WIDTH'(r_init_cnt + 1'b1);
        if (r_init_cnt == '1) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_accept) begin
          w_csb0_nxt   = 1'b0;
          w_web0_nxt   = !w_sel.we;
          w_wmask0_nxt = w_sel.we ? NUM_WMASKS'(w_sel.wmask) : '0;
          w_spare0_nxt = w_sel.we & w_sel.spare_wen;
          w_addr0_nxt  = ADDR_WIDTH'(w_sel.addr);
          w_din0_nxt   = DATA_WIDTH'(w_sel.wdata);
          w_push       = !w_sel.we;
          w_push_own   = w_gnt[1];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RESET_STATE;
      r_init_cnt  <= '0;
      r_init_done <= (RESET_STATE == RUN);
      r_csb0      <= 1'b1;
      r_web0      <= 1'b1;
      r_wmask0    <= '0;
      r_spare0    <= 1'b0;
      r_addr0     <= '0;
      r_din0      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_cnt  <= w_init_cnt_nxt;
      r_init_done <= (w_state_nxt == RUN);
      r_csb0      <= w_csb0_nxt;
      r_web0      <= w_web0_nxt;
      r_wmask0    <= w_wmask0_nxt;
      r_spare0    <= w_spare0_nxt;
      r_addr0     <= w_addr0_nxt;
      r_din0      <= w_din0_nxt;
    end
  end

  // Owner tag rides two stages so capture lines up with the macro's valid dout window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t1_vld  <= 1'b0;
      r_t1_own  <= 1'b0;
      r_t2_vld  <= 1'b0;
      r_t2_own  <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_t1_vld  <= w_push;
      r_t1_own  <= w_push_own;
      r_t2_vld  <= r_t1_vld;
      r_t2_own  <= r_t1_own;
      r_rvalid0 <= r_t2_vld & !r_t2_own;
      r_rvalid1 <= r_t2_vld & r_t2_own;
      if (r_t2_vld & !r_t2_own) r_rdata0 <= sram_dout0;
      if (r_t2_vld & r_t2_own)  r_rdata1 <= sram_dout0;
    end
  end

  assign r0_ready        = w_gnt[0];
  assign r1_ready        = w_gnt[1];
  assign r0_rvalid       = r_rvalid0;
  assign r1_rvalid       = r_rvalid1;
  assign r0_rdata        = r_rdata0;
  assign r1_rdata        = r_rdata1;
  assign sram_csb0       = r_csb0;
  assign sram_web0       = r_web0;
  assign sram_wmask0     = r_wmask0;
  assign sram_spare_wen0 = r_spare0;
  assign sram_addr0      = r_addr0;
  assign sram_din0       = r_din0;
  assign init_done       = r_init_done;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural 1RW macro plus a rule-level reference for grants and responses.
module tb_sram_port_arbiter;

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 33;
  localparam int unsigned NM    = 4;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef SRAM_ARB_INIT_EN
  localparam int INIT_CYC = DEPTH;
`else
  localparam int INIT_CYC = 0;
`endif

  logic          clk, rst_n;
  logic          r0_valid, r0_ready, r0_we, r0_spare_wen, r0_rvalid;
  logic [NM-1:0] r0_wmask;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_valid, r1_ready, r1_we, r1_spare_wen, r1_rvalid;
  logic [NM-1:0] r1_wmask;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic          sram_csb0, sram_web0, sram_spare_wen0, init_done;
  logic [NM-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0, sram_dout0;

  sram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_wmask(r0_wmask),
    .r0_spare_wen(r0_spare_wen), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_wmask(r1_wmask),
    .r1_spare_wen(r1_spare_wen), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_spare_wen0(sram_spare_wen0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_dout0(sram_dout0), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: pins sampled on rise, write committed and read data driven on fall, dout X after rise.
  logic [DW-1:0] mem [DEPTH];
  logic          m_csb = 1'b1, m_web = 1'b1, m_spare = 1'b0;
  logic [NM-1:0] m_wmask = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_din = '0;

  always @(posedge clk or negedge clk) begin
    if (clk) begin
      m_csb = sram_csb0; m_web = sram_web0; m_wmask = sram_wmask0;
      m_spare = sram_spare_wen0; m_addr = sram_addr0; m_din = sram_din0;
      sram_dout0 <= 'x;
    end else if (!m_csb) begin
      if (!m_web) begin
        for (int b = 0; b < int'(NM); b++)
          if (m_wmask[b]) mem[m_addr][8*b +: 8] = m_din[8*b +: 8];
        if (m_spare) mem[m_addr][32] = m_din[32];
      end else begin
        sram_dout0 = mem[m_addr];
      end
    end
  end

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } rsp_t;

  logic [DW-1:0] ref_mem [DEPTH];
  rsp_t          q0[$], q1[$];
  logic          ref_last;
  int            ref_init_left;
  int            cyc, checks, failures;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int n, input logic v, input logic we, input logic [NM-1:0] m,
                       input logic sp, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (n == 0) begin
      r0_valid = v; r0_we = we; r0_wmask = m; r0_spare_wen = sp; r0_addr = a; r0_wdata = d;
    end else begin
      r1_valid = v; r1_we = we; r1_wmask = m; r1_spare_wen = sp; r1_addr = a; r1_wdata = d;
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  // Reference effect of an accepted request: writes update memory, reads expect data 3 observed cycles later.
  task automatic apply(input int n, input logic we, input logic [NM-1:0] m, input logic sp,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    rsp_t r;
    if (we) begin
      for (int b = 0; b < int'(NM); b++)
        if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      if (sp) ref_mem[a][32] = d[32];
    end else begin
      r.cyc = cyc + 3; r.data = ref_mem[a];
      if (n == 0) q0.push_back(r); else q1.push_back(r);
    end
  endtask

  task automatic tick();
    logic [1:0] v, eg;
    logic       e0, e1;
    @(negedge clk);
    v = {r1_valid, r0_valid};
    if (ref_init_left != 0) eg = 2'b00;
    else if (v == 2'b11)    eg = ref_last ? 2'b01 : 2'b10;
    else                    eg = v;
    chk("init_done", 64'(init_done), 64'(ref_init_left == 0));
    chk("r0_ready", 64'(r0_ready), 64'(eg[0]));
    chk("r1_ready", 64'(r1_ready), 64'(eg[1]));
    e0 = (q0.size() != 0) && (q0[0].cyc == cyc);
    e1 = (q1.size() != 0) && (q1[0].cyc == cyc);
    chk("r0_rvalid", 64'(r0_rvalid), 64'(e0));
    chk("r1_rvalid", 64'(r1_rvalid), 64'(e1));
    if (e0) begin chk("r0_rdata", 64'(r0_rdata), 64'(q0[0].data)); void'(q0.pop_front()); end
    if (e1) begin chk("r1_rdata", 64'(r1_rdata), 64'(q1[0].data)); void'(q1.pop_front()); end
    if (eg[0]) apply(0, r0_we, r0_wmask, r0_spare_wen, r0_addr, r0_wdata);
    if (eg[1]) apply(1, r1_we, r1_wmask, r1_spare_wen, r1_addr, r1_wdata);
    if (eg != 2'b00) ref_last = eg[1];
    if (ref_init_left != 0) ref_init_left--;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    q0.delete(); q1.delete();
    ref_last      = 1'b1;
    ref_init_left = INIT_CYC;
    if (INIT_CYC != 0) for (int a = 0; a < int'(DEPTH); a++) ref_mem[a] = '0;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    ref_last = 1'b1; ref_init_left = 0;
    rst_n = 1'b1;
    idle();
    for (int a = 0; a < int'(DEPTH); a++) begin
      mem[a]     = DW'({$urandom(), $urandom()});
      ref_mem[a] = mem[a];
    end
    #1 rst_n = 1'b0;
    #1;
    chk("rst_csb0", 64'(sram_csb0), 64'd1);
    chk("rst_web0", 64'(sram_web0), 64'd1);
    chk("rst_wmask0", 64'(sram_wmask0), 64'd0);
    chk("rst_spare0", 64'(sram_spare_wen0), 64'd0);
    chk("rst_addr0", 64'(sram_addr0), 64'd0);
    chk("rst_din0", 64'(sram_din0), 64'd0);
    chk("rst_rvalid", 64'({r1_rvalid, r0_rvalid}), 64'd0);
    chk("rst_rdata", 64'(r0_rdata | r1_rdata), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'(INIT_CYC == 0));
    repeat (2) @(posedge clk);
    #1 release_reset();

    // Both requesters pressing during any init sweep must see no ready.
    drive(0, 1'b1, 1'b0, '0, 1'b0, 6'd63, '0);
    drive(1, 1'b1, 1'b0, '0, 1'b0, 6'd62, '0);
    repeat (INIT_CYC) tick();
    idle();

    // Write then read with full mask and spare bit.
    drive(0, 1'b1, 1'b1, 4'hF, 1'b1, 6'd5, 33'h1_DEADBEEF);
    tick();
    chk("wr_csb0", 64'(sram_csb0), 64'd0);
    chk("wr_web0", 64'(sram_web0), 64'd0);
    chk("wr_addr0", 64'(sram_addr0), 64'd5);
    chk("wr_din0", 64'(sram_din0), 64'h1_DEADBEEF);
    chk("wr_wmask0", 64'(sram_wmask0), 64'hF);
    chk("wr_spare0", 64'(sram_spare_wen0), 64'd1);
    drive(0, 1'b1, 1'b0, 4'hF, 1'b1, 6'd5, '0);
    tick();
    chk("rd_web0", 64'(sram_web0), 64'd1);
    chk("rd_wmask0", 64'(sram_wmask0), 64'd0);
    chk("rd_spare0", 64'(sram_spare_wen0), 64'd0);
    idle();
    tick();
    chk("idle_csb0", 64'(sram_csb0), 64'd1);
    chk("idle_addr_hold", 64'(sram_addr0), 64'd5);
    tick();
    chk("wr_rd_rvalid", 64'(r0_rvalid), 64'd1);
    chk("wr_rd_rdata", 64'(r0_rdata), 64'h1_DEADBEEF);
    tick();

    // Byte-masked overwrite.
    drive(0, 1'b1, 1'b1, 4'hF, 1'b1, 6'd9, 33'h0_11223344);
    tick();
    drive(0, 1'b1, 1'b1, 4'b0101, 1'b0, 6'd9, 33'h0_AABBCCDD);
    tick();
    drive(0, 1'b1, 1'b0, '0, 1'b0, 6'd9, '0);
    tick();
    idle();
    repeat (2) tick();
    chk("mask_rvalid", 64'(r0_rvalid), 64'd1);
    chk("mask_rdata", 64'(r0_rdata), 64'h0_11BB33DD);
    repeat (2) tick();

    // Contention: both reading for four cycles, grants alternate.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 1'b0, '0, 1'b0, AW'(10 + i), '0);
      drive(1, 1'b1, 1'b0, '0, 1'b0, AW'(20 + i), '0);
      tick();
    end
    idle();
    repeat (4) tick();

    // Back-to-back reads from requester 1.
    for (int i = 0; i < 8; i++) begin
      drive(1, 1'b1, 1'b0, '0, 1'b0, AW'(i), '0);
      tick();
    end
    idle();
    repeat (4) tick();

    // Random mixed traffic on a small address window.
    repeat (400) begin
      for (int n = 0; n < 2; n++)
        drive(n, 1'($urandom_range(0, 9) < 6), 1'($urandom()), NM'($urandom()), 1'($urandom()),
              AW'($urandom_range(0, 15)), DW'({$urandom(), $urandom()}));
      tick();
    end
    idle();
    repeat (5) tick();
    chk("queues_drained", 64'(q0.size() + q1.size()), 64'd0);

    // Reset one cycle after a read accept drops the response.
    drive(0, 1'b1, 1'b0, '0, 1'b0, 6'd3, '0);
    tick();
    idle();
    chk("pre_rst_csb0", 64'(sram_csb0), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_csb0", 64'(sram_csb0), 64'd1);
    chk("mid_rst_web0", 64'(sram_web0), 64'd1);
    chk("mid_rst_addr0", 64'(sram_addr0), 64'd0);
    repeat (2) @(posedge clk);
    #1 release_reset();
    repeat (INIT_CYC + 6) tick();
    chk("post_rst_queues", 64'(q0.size() + q1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
